mem_access_arbiter: RTL
=======================

// Module: mem_access_arbiter
// PURPOSE
//  Shares the core's single-port 16-bit memory between instruction fetch (IF) and data access (DM).
//  Sits between the multicycle core and memory, and drives the memR/memW/address/data bus.
//  A 3-state FSM serialises the accesses and counts MEM_LAT wait cycles per access.
//  Arbitration is data-priority with a starvation guard for fetch.
// PARAMETERS
//  ADDR_W        16  address width
//  DATA_W        16  data width
//  MEM_LAT       2   cycles memR/memW is held per access (>=1)
//  MAX_DATA_RUN  2   max consecutive DM grants while IF is pending (>=1)
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  if_req     in   1       fetch request (read only)
//  if_addr    in   ADDR_W  fetch address
//  if_ack     out  1       one-cycle pulse: fetch done, if_rdata valid
//  if_rdata   out  DATA_W  registered fetch data
//  dm_req     in   1       data request
//  dm_we      in   1       1 = store, 0 = load
//  dm_addr    in   ADDR_W  data address
//  dm_wdata   in   DATA_W  store data
//  dm_ack     out  1       one-cycle pulse: data access done
//  dm_rdata   out  DATA_W  registered load data
//  mem_addr   out  ADDR_W  memory address (registered at grant)
//  mem_wdata  out  DATA_W  memory write data (registered at grant)
//  memR       out  1       memory read strobe
//  memW       out  1       memory write strobe
//  mem_rdata  in   DATA_W  memory read data, valid in the last strobe cycle
//  busy       out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, reset=0): every output is 0, state = IDLE, run counter = 0. memR/memW drop immediately.
//  States and transitions:
//   - IDLE: if any request is high at the edge, grant a source, latch its address and data, go to ACCESS.
//   - ACCESS: memR (load/fetch) or memW (store) is high for exactly MEM_LAT cycles.
//     mem_rdata is captured at the final ACCESS edge, then go to RESP.
//   - RESP: the granted source's ack is high for one cycle. Next state is always IDLE.
//  Latency: request sampled at edge 0 -> strobe in cycles 1..MEM_LAT -> ack in cycle MEM_LAT+1.
//   Throughput is one access per MEM_LAT+2 cycles.
//  Arbitration at an IDLE edge:
//   - DM wins if both requests are high, unless run_cnt==MAX_DATA_RUN; then IF wins.
//   - run_cnt increments on a DM grant made while if_req=1. It clears on an IF grant or on a DM grant with if_req=0.
//   - run_cnt is $clog2(MAX_DATA_RUN+1) bits wide and saturates.
//  Handshake:
//   - The requester holds req, addr and data until its ack. On the ack edge it drops req or presents the next request.
//   - Inputs are sampled only at the grant edge. Later changes are ignored for that access.
//   - A request withdrawn before grant has no effect.
//   - A request withdrawn after grant still completes, and its ack still pulses.
//   - A request arriving during ACCESS or RESP waits for IDLE.
//  Data outputs:
//   - Stores: memR=0, dm_ack pulses, dm_rdata is unchanged.
//   - Loads and fetches: the source's rdata updates only on its own access. It holds between accesses.
//   - if_ack and dm_ack are never high together. memR and memW are never high together.
//  Reset mid-access aborts it with no ack. After release, FSM is IDLE and still-high requests are re-arbitrated.
// STRUCTURE
//  Shared header mem_arb_defs.vh holds:
//   - state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2 (2'd3 recovers to IDLE)
//   - source codes SRC_IF=1'b0, SRC_DM=1'b1
//  Sub-module mem_arb_wait_ctr: loadable down-counter for the MEM_LAT wait, with a done flag.
//  Grant logic and run_cnt stay inline.
// TESTING (MEM_LAT=2, MAX_DATA_RUN=2)
//  1. Reset low for 3 cycles, no requests -> all outputs 0, busy=0.
//     Release with no requests -> state stays IDLE.
//  2. if_req=1, if_addr=0x0004, mem_rdata=0x9278.
//     -> mem_addr=0x0004, memR=1 for cycles 1-2.
//     -> if_ack=1 in cycle 3, if_rdata=0x9278, dm_ack=0.
//  3. dm_req=1, dm_we=1, dm_addr=0x0010, dm_wdata=0xBEEF.
//     -> memW=1 for 2 cycles with mem_wdata=0xBEEF, memR=0.
//     -> dm_ack pulses, dm_rdata unchanged.
//  4. if_req and dm_req both held high for 6 grants -> grant order DM,DM,IF,DM,DM,IF.
//     Each ack is a single cycle, spaced 4 cycles apart.
//  5. Reset pulled low in cycle 1 of a fetch -> memR=0 at once, no if_ack.
//     After release with if_req still high -> a fresh grant, ack 3 cycles later.
//  6. if_req dropped in cycle 1 after grant -> if_ack still pulses.
//     dm_req (load 0x0020) raised in cycle 2 -> granted at the next IDLE edge, dm_rdata=mem_rdata.

Source files
------------

// File: rtl/mem_access_arbiter_pkg.sv
// Shared encodings for the memory access arbiter: FSM states, source codes and
// the grant record carried from the grant edge to the response cycle.
package mem_access_arbiter_pkg;

    // 2'd3 is unreachable and falls back to ST_IDLE in the next-state logic.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_DM = 1'b1;

    typedef struct packed {
        logic src;
        logic we;
    } grant_t;

    // Data wins a collision unless it has already used its run allowance.
    function automatic logic pick_dm(input logic if_req,
                                     input logic dm_req,
                                     input logic run_full);
        return dm_req && !(if_req && run_full);
    endfunction

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// Loadable down-counter timing the memory strobe; done is high in the last
// strobe cycle (count == 1). Idles at zero until reloaded.
module mem_arb_wait_ctr #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);
    localparam int CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(LAT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == CW'(1));

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one single-port memory between fetch and data access: one access per
// MEM_LAT+2 cycles, data priority with a bounded run while fetch is waiting.
module mem_access_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_LAT      = 2,
    parameter int MAX_DATA_RUN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              memR,
    output logic              memW,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    import mem_access_arbiter_pkg::*;

    localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

    state_t           state;
    state_t           state_nxt;
    grant_t           gnt_q;
    logic [RUN_W-1:0] run_cnt;
    logic             any_req;
    logic             grant_dm;
    logic             do_grant;
    logic             lat_done;
    logic             capture;

    assign any_req  = if_req | dm_req;
    assign grant_dm = pick_dm(if_req, dm_req, run_cnt == RUN_MAX);
    assign do_grant = (state == ST_IDLE) && any_req;
    assign capture  = (state == ST_ACCESS) && lat_done && !gnt_q.we;

    mem_arb_wait_ctr #(
        .LAT (MEM_LAT)
    ) u_wait_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (do_grant),
        .en    (state == ST_ACCESS),
        .done  (lat_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes and acks decode straight from state so an async reset kills them at once.
    always_comb begin
        state_nxt = state;
        memR      = 1'b0;
        memW      = 1'b0;
        if_ack    = 1'b0;
        dm_ack    = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                memR = !gnt_q.we;
                memW = gnt_q.we;
                if (lat_done) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if_ack    = (gnt_q.src == SRC_IF);
                dm_ack    = (gnt_q.src == SRC_DM);
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Requester inputs are sampled only here; later changes do not affect the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            run_cnt   <= '0;
        end else if (do_grant) begin
            gnt_q.src <= grant_dm ? SRC_DM : SRC_IF;
            gnt_q.we  <= grant_dm & dm_we;
            mem_addr  <= grant_dm ? dm_addr : if_addr;
            if (grant_dm) begin
                mem_wdata <= dm_wdata;
            end
            if (grant_dm && if_req) begin
                run_cnt <= (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
            end else begin
                run_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata <= '0;
            dm_rdata <= '0;
        end else if (capture) begin
            if (gnt_q.src == SRC_DM) begin
                dm_rdata <= mem_rdata;
            end else begin
                if_rdata <= mem_rdata;
            end
        end
    end

endmodule
